// File: rtl/fc_pkg.sv
// Shared encodings for the FC command sequencer: command codes, FSM states,
// buffer select codes and default widths.
package fc_pkg;

    localparam int FC_SIZE_W = 21;
    localparam int FC_CMD_W  = 3;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_LOAD_F = 3'd1,
        CMD_LOAD_B = 3'd2,
        CMD_LOAD_W = 3'd3,
        CMD_RUN    = 3'd4,
        CMD_CLEAR  = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BUF_FEAT = 2'd0,
        BUF_BIAS = 2'd1,
        BUF_WGT  = 2'd2
    } buf_sel_e;

    function automatic logic is_load_cmd(input logic [2:0] c);
        return (c == CMD_LOAD_F) || (c == CMD_LOAD_B) || (c == CMD_LOAD_W);
    endfunction

endpackage

// File: rtl/fc_beat_counter.sv
// Beat counter for buffer loads: latches the word count, steps once per
// accepted beat, and flags the final beat and the empty-load case.
module fc_beat_counter #(
    parameter int W = 21
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] size_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] size_q;

    // Hold on the final beat so the counter can never pass size-1 or wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            size_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                size_q <= size_i;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (size_q == '0);
    assign last_o = !zero_o && (cnt_q == size_q - 1'b1);

endmodule

// File: rtl/fc_seq_ctrl.sv
// FC command sequencer: loads feature/bias/weight buffers from AXIS, starts the
// core and tracks sticky status. Optional tlast checking: FC_SEQ_TLAST_CHECK_EN.
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int SIZE_W = FC_SIZE_W,
    parameter int CMD_W  = FC_CMD_W
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  command,
    input  logic [SIZE_W-1:0] size,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              buf_we,
    output logic [1:0]        buf_sel,
    output logic [SIZE_W-1:0] buf_addr,
    output logic              core_start,
    input  logic              core_done,
    output logic              F_writedone,
    output logic              B_writedone,
    output logic              W_writedone,
    output logic              FC_DONE,
    output logic              busy,
    output logic              err
);

    state_e     state_q;
    buf_sel_e   sel_q;
    logic       start_q, f_wd_q, b_wd_q, w_wd_q, fc_done_q, err_q;
    logic [2:0] cmd_code;
    logic       is_clear, load_go, accept, cnt_last, cnt_zero;

    assign cmd_code = command[2:0];
    assign is_clear = cmd_valid && (cmd_code == CMD_CLEAR);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign load_go  = cmd_valid && !busy && is_load_cmd(cmd_code);

    assign s_axis_tready = (state_q == ST_LOAD) && !cnt_zero;
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign buf_we        = accept;

    fc_beat_counter #(.W(SIZE_W)) u_cnt (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .load_i (load_go),
        .clr_i  (is_clear),
        .inc_i  (accept),
        .size_i (size),
        .cnt_o  (buf_addr),
        .last_o (cnt_last),
        .zero_o (cnt_zero)
    );

`ifndef FC_SEQ_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            sel_q     <= BUF_FEAT;
            start_q   <= 1'b0;
            f_wd_q    <= 1'b0;
            b_wd_q    <= 1'b0;
            w_wd_q    <= 1'b0;
            fc_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (is_clear) begin
                // CLEAR doubles as the abort path out of LOAD and RUN.
                state_q   <= ST_IDLE;
                f_wd_q    <= 1'b0;
                b_wd_q    <= 1'b0;
                w_wd_q    <= 1'b0;
                fc_done_q <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                if (cmd_valid && busy) begin
                    err_q <= 1'b1;
                end
                unique case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (cmd_valid) begin
                            case (cmd_code)
                                CMD_LOAD_F: begin
                                    f_wd_q    <= 1'b0;
                                    fc_done_q <= 1'b0;
                                    sel_q     <= BUF_FEAT;
                                    state_q   <= ST_LOAD;
                                end
                                CMD_LOAD_B: begin
                                    b_wd_q    <= 1'b0;
                                    fc_done_q <= 1'b0;
                                    sel_q     <= BUF_BIAS;
                                    state_q   <= ST_LOAD;
                                end
                                CMD_LOAD_W: begin
                                    w_wd_q    <= 1'b0;
                                    fc_done_q <= 1'b0;
                                    sel_q     <= BUF_WGT;
                                    state_q   <= ST_LOAD;
                                end
                                CMD_RUN: begin
                                    if (f_wd_q && b_wd_q && w_wd_q) begin
                                        fc_done_q <= 1'b0;
                                        start_q   <= 1'b1;
                                        state_q   <= ST_RUN;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_LOAD: begin
`ifdef FC_SEQ_TLAST_CHECK_EN
                        if (accept && (s_axis_tlast != cnt_last)) begin
                            err_q <= 1'b1;
                        end
`endif
                        if (cnt_zero || (accept && cnt_last)) begin
                            state_q <= ST_IDLE;
                            case (sel_q)
                                BUF_FEAT: f_wd_q <= 1'b1;
                                BUF_BIAS: b_wd_q <= 1'b1;
                                default:  w_wd_q <= 1'b1;
                            endcase
                        end
                    end
                    ST_RUN: begin
                        // A done coincident with our own start pulse is stale.
                        if (core_done && !start_q) begin
                            fc_done_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                endcase
            end
        end
    end

    assign buf_sel     = sel_q;
    assign core_start  = start_q;
    assign F_writedone = f_wd_q;
    assign B_writedone = b_wd_q;
    assign W_writedone = w_wd_q;
    assign FC_DONE     = fc_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl; buffer writes are tracked by a scoreboard.
module tb_fc_seq_ctrl;

    localparam int SIZE_W = 21;
    localparam int CMD_W  = 3;

    localparam logic [2:0] C_NOP = 3'd0, C_LF = 3'd1, C_LB = 3'd2, C_LW = 3'd3,
                           C_RUN = 3'd4, C_CLR = 3'd5;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic              cmd_valid;
    logic [CMD_W-1:0]  command;
    logic [SIZE_W-1:0] size;
    logic              s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic              buf_we;
    logic [1:0]        buf_sel;
    logic [SIZE_W-1:0] buf_addr;
    logic              core_start, core_done;
    logic              F_writedone, B_writedone, W_writedone, FC_DONE, busy, err;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int we_cnt    = 0;
    logic [SIZE_W+1:0] exp_q[$];

    fc_seq_ctrl #(.SIZE_W(SIZE_W), .CMD_W(CMD_W)) dut (
        .CLK(CLK), .RESETN(RESETN), .cmd_valid(cmd_valid), .command(command),
        .size(size), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .buf_we(buf_we), .buf_sel(buf_sel),
        .buf_addr(buf_addr), .core_start(core_start), .core_done(core_done),
        .F_writedone(F_writedone), .B_writedone(B_writedone),
        .W_writedone(W_writedone), .FC_DONE(FC_DONE), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard consumer: every write strobe must match the next expected beat.
    always @(negedge CLK) begin
        if (RESETN) begin
            if (core_start) start_cnt++;
            if (buf_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("we_unexpected", 32'(buf_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [SIZE_W+1:0] e;
                    e = exp_q.pop_front();
                    check_eq("buf_addr", 32'(buf_addr), 32'(e[SIZE_W-1:0]));
                    check_eq("buf_sel", 32'(buf_sel), 32'(e[SIZE_W+1:SIZE_W]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_cmd(input logic [2:0] c, input int n);
        cmd_valid = 1'b1;
        command   = c;
        size      = SIZE_W'(n);
        tick();
        cmd_valid = 1'b0;
        command   = '0;
        size      = '0;
    endtask

    task automatic send_beat(input logic [1:0] sel, input int addr, input logic lst);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = lst;
        exp_q.push_back({sel, SIZE_W'(addr)});
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic load_buf(input logic [2:0] c, input int n, input logic [1:0] sel);
        issue_cmd(c, n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 1) tick();
            send_beat(sel, i, i == n - 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 {20'd0, s_axis_tready, buf_we, core_start, F_writedone, B_writedone,
                  W_writedone, FC_DONE, busy, err, 1'b0, buf_sel}, 32'd0);
        check_eq({tag, "_addr"}, 32'(buf_addr), 32'd0);
    endtask

    initial begin
        int s0, w0;
        RESETN = 1'b0; cmd_valid = 1'b0; command = '0; size = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; core_done = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) tick();
        RESETN = 1'b1;
        tick();

        // 1: LOAD_F size 4 with gaps
        w0 = we_cnt;
        issue_cmd(C_LF, 4);
        check_eq("t1_tready_on", 32'(s_axis_tready), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) check_eq("t1_fwd_pre", 32'(F_writedone), 32'd0);
            send_beat(2'd0, i, i == 3);
        end
        check_eq("t1_fwd", 32'(F_writedone), 32'd1);
        check_eq("t1_tready_off", 32'(s_axis_tready), 32'd0);
        check_eq("t1_busy_off", 32'(busy), 32'd0);
        check_eq("t1_we_cnt", 32'(we_cnt - w0), 32'd4);
        check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: RUN with W missing
        load_buf(C_LB, 2, 2'd1);
        s0 = start_cnt;
        issue_cmd(C_RUN, 0);
        repeat (2) tick();
        check_eq("t2_err", 32'(err), 32'd1);
        check_eq("t2_busy", 32'(busy), 32'd0);
        check_eq("t2_no_start", 32'(start_cnt - s0), 32'd0);
        issue_cmd(C_CLR, 0);
        check_eq("t2_clr_err", 32'(err), 32'd0);
        check_eq("t2_clr_fb", 32'({F_writedone, B_writedone}), 32'd0);

        // 3: full load, RUN, core_done 10 cycles later
        load_buf(C_LF, 4, 2'd0);
        load_buf(C_LB, 2, 2'd1);
        load_buf(C_LW, 8, 2'd2);
        check_eq("t3_all_wd", 32'({F_writedone, B_writedone, W_writedone}), 32'd7);
        s0 = start_cnt;
        issue_cmd(C_RUN, 0);
        check_eq("t3_start_hi", 32'(core_start), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t3_start_lo", 32'(core_start), 32'd0);
        repeat (8) tick();
        check_eq("t3_fcdone_pre", 32'(FC_DONE), 32'd0);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check_eq("t3_fcdone", 32'(FC_DONE), 32'd1);
        check_eq("t3_busy_off", 32'(busy), 32'd0);
        check_eq("t3_one_start", 32'(start_cnt - s0), 32'd1);
        // core_done alongside core_start must be ignored
        issue_cmd(C_RUN, 0);
        check_eq("t3b_fcdone_clr", 32'(FC_DONE), 32'd0);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check_eq("t3b_stale_done", 32'(FC_DONE), 32'd0);
        check_eq("t3b_busy", 32'(busy), 32'd1);
        core_done = 1'b1; tick(); core_done = 1'b0;
        check_eq("t3b_fcdone", 32'(FC_DONE), 32'd1);

        // 4: LOAD_W size 0 with tvalid held high
        w0 = we_cnt;
        s_axis_tvalid = 1'b1;
        issue_cmd(C_LW, 0);
        check_eq("t4_wd_clr", 32'(W_writedone), 32'd0);
        check_eq("t4_fcdone_clr", 32'(FC_DONE), 32'd0);
        check_eq("t4_tready", 32'(s_axis_tready), 32'd0);
        tick();
        check_eq("t4_wd", 32'(W_writedone), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        s_axis_tvalid = 1'b0;
        check_eq("t4_no_we", 32'(we_cnt - w0), 32'd0);

        // 5: command during RUN, CLEAR mid-LOAD, reset mid-RUN
        issue_cmd(C_RUN, 0);
        issue_cmd(C_LB, 3);
        check_eq("t5_err_busy", 32'(err), 32'd1);
        check_eq("t5_bwd_kept", 32'(B_writedone), 32'd1);
        check_eq("t5_still_run", 32'(busy), 32'd1);
        issue_cmd(C_CLR, 0);
        check_eq("t5_abort_run", 32'({busy, err, FC_DONE, F_writedone, B_writedone, W_writedone}), 32'd0);
        issue_cmd(C_LW, 4);
        send_beat(2'd2, 0, 1'b0);
        tick();
        send_beat(2'd2, 1, 1'b0);
        issue_cmd(C_CLR, 0);
        check_eq("t5_abort_load", 32'({busy, s_axis_tready, W_writedone, err}), 32'd0);
        check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        load_buf(C_LF, 1, 2'd0);
        load_buf(C_LB, 1, 2'd1);
        load_buf(C_LW, 3, 2'd2);
        issue_cmd(C_RUN, 0);
        issue_cmd(C_NOP, 0);
        check_eq("t5_err_nop", 32'(err), 32'd1);
        RESETN = 1'b0;
        #1;
        check_all_zero("t5_reset");
        tick();
        RESETN = 1'b1;
        tick();

        // 6: tlast on a non-final beat
        issue_cmd(C_LF, 3);
        send_beat(2'd0, 0, 1'b0);
        send_beat(2'd0, 1, 1'b1);
`ifdef FC_SEQ_TLAST_CHECK_EN
        check_eq("t6_err", 32'(err), 32'd1);
`else
        check_eq("t6_err", 32'(err), 32'd0);
`endif
        check_eq("t6_fwd_pre", 32'(F_writedone), 32'd0);
        send_beat(2'd0, 2, 1'b0);
        check_eq("t6_fwd", 32'(F_writedone), 32'd1);
        check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
